// File: rtl/collatz_pkg.sv
// Shared constants for the Collatz core, result FIFO and the I/O byte mux.
// Field widths, rd_sel byte encodings and status byte layout live here.
package collatz_pkg;

  localparam int SEED_BITS = 16;
  localparam int OLEN_BITS = 16;
  localparam int PLEN_BITS = 16;

  localparam logic [2:0] SEL_SEED_L = 3'd0;
  localparam logic [2:0] SEL_SEED_H = 3'd1;
  localparam logic [2:0] SEL_ORB_L  = 3'd2;
  localparam logic [2:0] SEL_ORB_H  = 3'd3;
  localparam logic [2:0] SEL_REC_L  = 3'd4;
  localparam logic [2:0] SEL_REC_H  = 3'd5;
  localparam logic [2:0] SEL_STATUS = 3'd6;
  localparam logic [2:0] SEL_ZERO   = 3'd7;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  function automatic logic [7:0] status_byte(
    input logic       ovf,
    input logic       is_full,
    input logic       is_empty,
    input logic [3:0] cnt
  );
    logic [7:0] s;
    s           = 8'h00;
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = is_full;
    s[ST_EMPTY] = is_empty;
    s[3:0]      = cnt;
    return s;
  endfunction

endpackage

// File: rtl/collatz_fifo_mem.sv
// Result storage: DEPTH x WIDTH register array,
// one synchronous write port and one asynchronous read port.
module collatz_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/collatz_result_fifo.sv
// Buffers finished Collatz runs for byte-serial host readout.
// Never stalls the core: results arriving while full are dropped and flagged.
module collatz_result_fifo
  import collatz_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int SEED_BITS = collatz_pkg::SEED_BITS,
  parameter int OLEN_BITS = collatz_pkg::OLEN_BITS,
  parameter int PLEN_BITS = collatz_pkg::PLEN_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   res_valid,
  input  logic [SEED_BITS-1:0]   res_seed,
  input  logic [OLEN_BITS-1:0]   res_orbit_len,
  input  logic [PLEN_BITS-1:0]   res_path_record,
  output logic                   res_ready,
  input  logic                   rd_pop,
  input  logic [2:0]             rd_sel,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = SEED_BITS + OLEN_BITS + PLEN_BITS;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          drop;
  logic [15:0]   h_seed;
  logic [15:0]   h_orbit;
  logic [15:0]   h_rec;
  logic [7:0]    cnt8;
  logic [7:0]    rd_next;

  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign res_ready = !full || rd_pop;
  assign push      = res_valid && res_ready;
  assign drop      = res_valid && !res_ready;
  assign pop       = rd_pop && !empty;
  assign wr_entry  = {res_seed, res_orbit_len, res_path_record};

  collatz_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stale array contents must not leak out while the FIFO is empty.
  assign h_seed  = empty ? 16'h0 : 16'(head[EW-1 -: SEED_BITS]);
  assign h_orbit = empty ? 16'h0 : 16'(head[PLEN_BITS +: OLEN_BITS]);
  assign h_rec   = empty ? 16'h0 : 16'(head[PLEN_BITS-1:0]);
  assign cnt8    = 8'(count);

  always_comb begin
    rd_next = 8'h00;
    case (rd_sel)
      SEL_SEED_L: rd_next = h_seed[7:0];
      SEL_SEED_H: rd_next = h_seed[15:8];
      SEL_ORB_L:  rd_next = h_orbit[7:0];
      SEL_ORB_H:  rd_next = h_orbit[15:8];
      SEL_REC_L:  rd_next = h_rec[7:0];
      SEL_REC_H:  rd_next = h_rec[15:8];
      SEL_STATUS: rd_next = status_byte(overflow, full, empty, cnt8[3:0]);
      default:    rd_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_data <= rd_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_collatz_result_fifo.sv
// Self-checking bench for collatz_result_fifo: vector table of operations
// with hand-derived flag/count expectations plus an entry scoreboard.
module tb_collatz_result_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic [15:0] res_seed;
  logic [15:0] res_orbit_len;
  logic [15:0] res_path_record;
  logic        res_ready;
  logic        rd_pop;
  logic [2:0]  rd_sel;
  logic [7:0]  rd_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] seed;
    logic [15:0] orbit;
    logic [15:0] rec;
  } ent_t;

  typedef struct {
    bit          chk;
    bit          stat;
    logic [7:0]  exp_stat;
    bit          v;
    logic [15:0] seed;
    logic [15:0] orbit;
    logic [15:0] rec;
    bit          pop;
    bit          clr;
    bit          rst;
    bit          exp_rdy;
    int          exp_cnt;
    bit          exp_ovf;
  } vec_t;

  ent_t sb[$];
  vec_t vecs[$];

  collatz_result_fifo #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .res_valid       (res_valid),
    .res_seed        (res_seed),
    .res_orbit_len   (res_orbit_len),
    .res_path_record (res_path_record),
    .res_ready       (res_ready),
    .rd_pop          (rd_pop),
    .rd_sel          (rd_sel),
    .rd_data         (rd_data),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] orb(input logic [15:0] s);
    return {8'h10 + s[7:0], 8'h20 + s[7:0]};
  endfunction

  function automatic logic [15:0] rec(input logic [15:0] s);
    return {8'h30 + s[7:0], 8'h40 + s[7:0]};
  endfunction

  function automatic logic [7:0] byte_of(input ent_t e, input int k);
    logic [7:0] b;
    case (k)
      0: b = e.seed[7:0];
      1: b = e.seed[15:8];
      2: b = e.orbit[7:0];
      3: b = e.orbit[15:8];
      4: b = e.rec[7:0];
      default: b = e.rec[15:8];
    endcase
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    res_valid       = 1'b0;
    res_seed        = 16'h0;
    res_orbit_len   = 16'h0;
    res_path_record = 16'h0;
    rd_pop          = 1'b0;
    clr_overflow    = 1'b0;
    reset           = 1'b0;
  endtask

  task automatic add(input bit chk, input bit stat, input logic [7:0] est,
                     input bit v, input logic [15:0] s, input logic [15:0] o,
                     input logic [15:0] r, input bit pop, input bit clr,
                     input bit rst, input bit rdy, input int cnt,
                     input bit ovf);
    vec_t t;
    t.chk = chk; t.stat = stat; t.exp_stat = est;
    t.v = v; t.seed = s; t.orbit = o; t.rec = r;
    t.pop = pop; t.clr = clr; t.rst = rst;
    t.exp_rdy = rdy; t.exp_cnt = cnt; t.exp_ovf = ovf;
    vecs.push_back(t);
  endtask

  task automatic add_push(input logic [15:0] s, input bit pop, input bit clr,
                          input bit chk, input bit rdy, input int cnt,
                          input bit ovf);
    add(chk, 0, 8'h0, 1, s, orb(s), rec(s), pop, clr, 0, rdy, cnt, ovf);
  endtask

  task automatic add_op(input bit chk, input bit stat, input logic [7:0] est,
                        input bit pop, input bit clr, input bit rst,
                        input bit rdy, input int cnt, input bit ovf);
    add(chk, stat, est, 0, 16'h0, 16'h0, 16'h0, pop, clr, rst, rdy, cnt, ovf);
  endtask

  task automatic check_head();
    ent_t  z;
    ent_t  e;
    z = '{16'h0, 16'h0, 16'h0};
    e = (sb.size() > 0) ? sb[0] : z;
    for (int k = 0; k < 6; k++) begin
      idle();
      rd_sel = 3'(k);
      cyc();
      check($sformatf("head_byte%0d", k), 32'(rd_data), 32'(byte_of(e, k)));
    end
  endtask

  initial begin
    idle();
    reset  = 1'b1;
    rd_sel = 3'd6;
    cyc();
    cyc();
    idle();
    rd_sel = 3'd6;
    #1 check("reset_ready", 32'(res_ready), 32'd1);
    cyc();
    check("reset_status", 32'(rd_data), 32'h20);
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    rd_sel = 3'd7;
    cyc();
    check("sel7_zero", 32'(rd_data), 32'h00);

    add(0, 0, 8'h0, 1, 16'h001B, 16'h006F, 16'h0000, 0, 0, 0, 1, 1, 0);
    add_op(1, 0, 8'h0, 1, 0, 0, 1, 0, 0);
    for (int s = 1; s <= 4; s++) add_push(16'(s), 0, 0, 0, 1, s, 0);
    add_push(16'h5, 0, 0, 0, 0, 4, 1);
    add_op(1, 1, 8'hC4, 1, 0, 0, 1, 3, 1);
    add_op(1, 0, 8'h0, 1, 0, 0, 1, 2, 1);
    add_op(1, 0, 8'h0, 1, 0, 0, 1, 1, 1);
    add_op(1, 0, 8'h0, 1, 0, 0, 1, 0, 1);
    add_op(0, 0, 8'h0, 1, 0, 0, 1, 0, 1);
    add_op(0, 1, 8'hA0, 0, 1, 0, 1, 0, 0);
    for (int s = 5; s <= 8; s++) add_push(16'(s), 0, 0, 0, 1, s - 4, 0);
    add_push(16'h9, 1, 0, 1, 1, 4, 0);
    for (int n = 3; n >= 0; n--) add_op(1, 0, 8'h0, 1, 0, 0, 1, n, 0);
    add_push(16'h000A, 1, 0, 0, 1, 1, 0);
    add_op(1, 0, 8'h0, 0, 0, 0, 1, 1, 0);
    add_push(16'h000B, 0, 0, 0, 1, 2, 0);
    add_push(16'h000C, 0, 0, 0, 1, 3, 0);
    add_push(16'h000D, 0, 0, 0, 1, 4, 0);
    add_push(16'h000E, 0, 1, 0, 0, 4, 1);
    add_op(1, 1, 8'hC4, 1, 0, 0, 1, 3, 1);
    add_op(0, 0, 8'h0, 0, 0, 1, 1, 0, 0);
    add_op(1, 1, 8'h20, 0, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      vec_t t;
      t = vecs[i];
      if (t.stat) begin
        idle();
        rd_sel = 3'd6;
        cyc();
        check($sformatf("v%0d_status", i), 32'(rd_data), 32'(t.exp_stat));
      end
      if (t.chk) check_head();
      idle();
      rd_sel          = 3'd7;
      res_valid       = t.v;
      res_seed        = t.seed;
      res_orbit_len   = t.orbit;
      res_path_record = t.rec;
      rd_pop          = t.pop;
      clr_overflow    = t.clr;
      reset           = t.rst;
      #1 check($sformatf("v%0d_ready", i), 32'(res_ready), 32'(t.exp_rdy));
      if (t.rst) sb.delete();
      else begin
        if (t.pop && sb.size() > 0) void'(sb.pop_front());
        if (t.v && t.exp_rdy) sb.push_back('{t.seed, t.orbit, t.rec});
      end
      cyc();
      idle();
      check($sformatf("v%0d_count", i), 32'(count), 32'(t.exp_cnt));
      check($sformatf("v%0d_full", i), 32'(full), 32'(t.exp_cnt == 4));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(t.exp_cnt == 0));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(t.exp_ovf));
      if (t.rst) check($sformatf("v%0d_rst_data", i), 32'(rd_data), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
